pspin_her_queue: RTL and testbench

// - Elastic HER buffer between the HER generator and the PsPIN wrapper HER port.
// - Decouples her_ready backpressure from the ingress DMA completion path.
// - Registers the wide HER bundle so the combinational context lookup in the generator
//   is cut off from PsPIN input timing.
// - FWFT FIFO with a registered output stage, occupancy tracking and a synchronous flush.
//

---
 rtl/pspin_her_pkg.sv | 48 ++++
 rtl/pspin_her_queue_ram.sv | 23 ++
 rtl/pspin_her_queue.sv | 137 +++++++++++++
 tb/tb_pspin_her_queue.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pspin_her_pkg.sv
// HER bundle layout shared by the generator, the HER queue and the PsPIN wrapper.
// Fields are packed LSB-first: msgid, eom, addr, size, xfer, meta.
package pspin_her_pkg;

  localparam int MSGID_W   = 10;
  localparam int META_W    = 608;
  localparam int MSGID_LSB = 0;
  localparam int EOM_BIT   = MSGID_LSB + MSGID_W;
  localparam int ADDR_LSB  = EOM_BIT + 1;
  localparam int SIZE_LSB  = ADDR_LSB + 32;
  localparam int XFER_LSB  = SIZE_LSB + 32;
  localparam int META_LSB  = XFER_LSB + 32;
  localparam int HER_W     = META_LSB + META_W;

  // Meta sub-fields. The first member of a packed struct lands in the MSBs.
  typedef struct packed {
    logic [223:0] user_data;
    logic [31:0]  host_mem_size;
    logic [63:0]  host_mem_addr;
    logic [31:0]  handler_mem_size;
    logic [31:0]  handler_mem_addr;
    logic [31:0]  th_size;
    logic [31:0]  ph_size;
    logic [31:0]  hh_size;
    logic [31:0]  th_addr;
    logic [31:0]  ph_addr;
    logic [31:0]  hh_addr;
    logic [31:0]  ctx_id;
  } her_meta_t;

  typedef struct packed {
    her_meta_t          meta;
    logic [31:0]        xfer;
    logic [31:0]        size;
    logic [31:0]        addr;
    logic               eom;
    logic [MSGID_W-1:0] msgid;
  } her_t;

  function automatic logic [HER_W-1:0] her_pack(input her_t h);
    return h;
  endfunction

  function automatic her_t her_unpack(input logic [HER_W-1:0] v);
    return v;
  endfunction

endpackage

// File: rtl/pspin_her_queue_ram.sv
// Simple dual-port HER storage: synchronous write, asynchronous read (LUTRAM).
module pspin_her_queue_ram #(
  parameter int DEPTH = 15,
  parameter int WIDTH = 715,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/pspin_her_queue.sv
// Elastic FWFT HER FIFO: DEPTH-1 RAM slots plus a registered output stage.
// Optional statistics ports are enabled with `PSPIN_HER_QUEUE_STATS_EN.
module pspin_her_queue
  import pspin_her_pkg::*;
#(
  parameter int DEPTH         = 16,
  parameter int HER_WIDTH     = HER_W,
  parameter int C_MSGID_WIDTH = 10
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     flush,
  input  logic [HER_WIDTH-1:0]     s_her_data,
  input  logic                     s_her_valid,
  output logic                     s_her_ready,
  output logic [HER_WIDTH-1:0]     m_her_data,
  output logic                     m_her_valid,
  input  logic                     m_her_ready,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic                     full,
  output logic                     empty
`ifdef PSPIN_HER_QUEUE_STATS_EN
  ,
  output logic [31:0]              stat_her_cnt,
  output logic [31:0]              stat_eom_cnt,
  output logic [$clog2(DEPTH):0]   stat_max_occ,
  output logic [31:0]              stat_stall_cnt
`endif
);

  localparam int RAM_D = DEPTH - 1;
  localparam int PW    = $clog2(DEPTH);
  localparam int OW    = PW + 1;
  localparam logic [PW-1:0] PTR_LAST = PW'(RAM_D - 1);

  // The eom decode relies on msgid sitting directly below the eom bit.
  if (C_MSGID_WIDTH != EOM_BIT - MSGID_LSB || HER_WIDTH <= EOM_BIT) begin : g_cfg_err
    $error("pspin_her_queue: HER layout does not match pspin_her_pkg");
  end

  logic [PW-1:0]        wr_ptr, rd_ptr, ram_cnt;
  logic [OW-1:0]        occ_q, occ_d;
  logic                 full_q, empty_q;
  logic                 push, pop, load, bypass, ram_we, ram_re;
  logic [HER_WIDTH-1:0] ram_rdata;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  assign s_her_ready = ~full_q;
  assign full        = full_q;
  assign empty       = empty_q;
  assign occupancy   = occ_q;

  assign push   = s_her_valid & ~full_q;
  assign pop    = m_her_valid & m_her_ready;
  // Output register is free to take a new HER this cycle.
  assign load   = ~m_her_valid | m_her_ready;
  assign ram_re = load & (ram_cnt != '0);
  assign bypass = load & (ram_cnt == '0) & push;
  assign ram_we = push & ~bypass & ~flush;

  always_comb begin
    occ_d = occ_q;
    case ({push, pop})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: occ_d = occ_q;
    endcase
  end

  pspin_her_queue_ram #(.DEPTH(RAM_D), .WIDTH(HER_WIDTH), .AW(PW)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (wr_ptr),
    .wdata (s_her_data),
    .raddr (rd_ptr),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      ram_cnt     <= '0;
      occ_q       <= '0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      m_her_valid <= 1'b0;
      m_her_data  <= '0;
    end else if (flush) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      ram_cnt     <= '0;
      occ_q       <= '0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      m_her_valid <= 1'b0;
    end else begin
      occ_q   <= occ_d;
      full_q  <= (occ_d == OW'(DEPTH));
      empty_q <= (occ_d == '0);
      if (ram_we) wr_ptr <= ptr_inc(wr_ptr);
      if (ram_re) rd_ptr <= ptr_inc(rd_ptr);
      case ({ram_we, ram_re})
        2'b10:   ram_cnt <= ram_cnt + 1'b1;
        2'b01:   ram_cnt <= ram_cnt - 1'b1;
        default: ram_cnt <= ram_cnt;
      endcase
      if (load) begin
        m_her_valid <= ram_re | push;
        if (ram_re)      m_her_data <= ram_rdata;
        else if (bypass) m_her_data <= s_her_data;
      end
    end
  end

`ifdef PSPIN_HER_QUEUE_STATS_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stat_her_cnt   <= '0;
      stat_eom_cnt   <= '0;
      stat_max_occ   <= '0;
      stat_stall_cnt <= '0;
    end else begin
      if (pop && !flush && stat_her_cnt != '1) stat_her_cnt <= stat_her_cnt + 1'b1;
      if (pop && !flush && m_her_data[EOM_BIT] && stat_eom_cnt != '1)
        stat_eom_cnt <= stat_eom_cnt + 1'b1;
      if (occ_q > stat_max_occ) stat_max_occ <= occ_q;
      if (m_her_valid && !m_her_ready && stat_stall_cnt != '1)
        stat_stall_cnt <= stat_stall_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_pspin_her_queue.sv
// Directed bench for pspin_her_queue with a queue-based reference model.
module tb_pspin_her_queue;
  import pspin_her_pkg::*;

  localparam int DEPTH = 16;
  localparam int OW    = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic             flush = 1'b0;
  logic [HER_W-1:0] s_her_data = '0;
  logic             s_her_valid = 1'b0;
  logic             s_her_ready;
  logic [HER_W-1:0] m_her_data;
  logic             m_her_valid;
  logic             m_her_ready = 1'b0;
  logic [OW-1:0]    occupancy;
  logic             full, empty;
`ifdef PSPIN_HER_QUEUE_STATS_EN
  logic [31:0]      stat_her_cnt, stat_eom_cnt, stat_stall_cnt;
  logic [OW-1:0]    stat_max_occ;
`endif

  int checks = 0;
  int errors = 0;

  pspin_her_queue #(.DEPTH(DEPTH), .HER_WIDTH(HER_W), .C_MSGID_WIDTH(10)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .flush       (flush),
    .s_her_data  (s_her_data),
    .s_her_valid (s_her_valid),
    .s_her_ready (s_her_ready),
    .m_her_data  (m_her_data),
    .m_her_valid (m_her_valid),
    .m_her_ready (m_her_ready),
    .occupancy   (occupancy),
    .full        (full),
    .empty       (empty)
`ifdef PSPIN_HER_QUEUE_STATS_EN
    ,
    .stat_her_cnt   (stat_her_cnt),
    .stat_eom_cnt   (stat_eom_cnt),
    .stat_max_occ   (stat_max_occ),
    .stat_stall_cnt (stat_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [HER_W-1:0] act, input logic [HER_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [HER_W-1:0] mk_her(input int id, input bit eom);
    her_t h;
    h = '0;
    h.msgid = 10'(id);
    h.eom   = eom;
    h.addr  = 32'h1000_0000 + 32'(id) * 32'd64;
    h.size  = 32'(id) + 32'd1;
    h.xfer  = ~32'(id);
    h.meta  = {19{32'(id) * 32'h9E37_79B9}};
    return her_pack(h);
  endfunction

  // Reference model: a plain queue of HERs plus statistics counters.
  logic [HER_W-1:0] mq[$];
  int m_her = 0, m_eom = 0, m_max = 0, m_stall = 0;

  always @(posedge clk or negedge rstn) begin : model
    bit pu, po;
    if (!rstn) begin
      mq.delete();
      m_her = 0; m_eom = 0; m_max = 0; m_stall = 0;
    end else begin
      pu = s_her_valid && (mq.size() < DEPTH);
      po = (mq.size() > 0) && m_her_ready;
      if (mq.size() > 0 && !m_her_ready) m_stall++;
      if (mq.size() > m_max) m_max = mq.size();
      if (flush) mq.delete();
      else begin
        if (po) begin
          m_her++;
          if (mq[0][EOM_BIT]) m_eom++;
          void'(mq.pop_front());
        end
        if (pu) mq.push_back(s_her_data);
      end
    end
  end

  always @(negedge clk) begin
    if (rstn) begin
      chk("occupancy", HER_W'(occupancy), HER_W'(mq.size()));
      chk("m_valid", HER_W'(m_her_valid), HER_W'(mq.size() != 0));
      chk("full", HER_W'(full), HER_W'(mq.size() == DEPTH));
      chk("empty", HER_W'(empty), HER_W'(mq.size() == 0));
      chk("s_ready", HER_W'(s_her_ready), HER_W'(mq.size() != DEPTH));
      if (mq.size() != 0) chk("m_data", m_her_data, mq[0]);
`ifdef PSPIN_HER_QUEUE_STATS_EN
      chk("stat_her", HER_W'(stat_her_cnt), HER_W'(m_her));
      chk("stat_eom", HER_W'(stat_eom_cnt), HER_W'(m_eom));
      chk("stat_max", HER_W'(stat_max_occ), HER_W'(m_max));
      chk("stat_stall", HER_W'(stat_stall_cnt), HER_W'(m_stall));
`endif
    end
  end

  // Inputs change on the falling edge; the DUT samples them on the rising edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rstn = 1'b0; s_her_valid = 1'b0; m_her_ready = 1'b0; flush = 1'b0;
    tick();
    rstn = 1'b1;
  endtask

  initial begin
    @(negedge clk);
    do_reset();

    // reset state
    chk("rst_occ", HER_W'(occupancy), '0);
    chk("rst_empty", HER_W'(empty), HER_W'(1));
    chk("rst_full", HER_W'(full), '0);
    chk("rst_s_ready", HER_W'(s_her_ready), HER_W'(1));
    chk("rst_m_valid", HER_W'(m_her_valid), '0);
    chk("rst_m_data", m_her_data, '0);

    // single HER, msgid 0x2A with eom
    m_her_ready = 1'b1; s_her_valid = 1'b1; s_her_data = mk_her(42, 1'b1);
    tick();
    s_her_valid = 1'b0;
    chk("single_valid", HER_W'(m_her_valid), HER_W'(1));
    chk("single_msgid", HER_W'(m_her_data[9:0]), HER_W'(10'h2A));
    chk("single_eom", HER_W'(m_her_data[10]), HER_W'(1));
    chk("single_data", m_her_data, mk_her(42, 1'b1));
    tick();
    chk("single_drained", HER_W'(empty), HER_W'(1));
`ifdef PSPIN_HER_QUEUE_STATS_EN
    chk("single_her_cnt", HER_W'(stat_her_cnt), HER_W'(1));
    chk("single_eom_cnt", HER_W'(stat_eom_cnt), HER_W'(1));
`endif

    // stalled output, offer 20 HERs, only 16 fit
    begin
      int acc = 0;
      m_her_ready = 1'b0;
      for (int i = 0; i < 20; i++) begin
        s_her_valid = 1'b1; s_her_data = mk_her(100 + i, i[0]);
        if (s_her_ready) acc++;
        tick();
      end
      s_her_valid = 1'b0;
      chk("fill_accepted", HER_W'(acc), HER_W'(16));
      chk("fill_occ", HER_W'(occupancy), HER_W'(16));
      chk("fill_full", HER_W'(full), HER_W'(1));
      chk("fill_s_ready", HER_W'(s_her_ready), '0);
      m_her_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
        chk("drain_order", HER_W'(m_her_data[9:0]), HER_W'(100 + i));
        tick();
      end
      chk("drain_empty", HER_W'(empty), HER_W'(1));
    end

    // streaming 1 HER/cycle
    for (int i = 0; i < 100; i++) begin
      s_her_valid = 1'b1; s_her_data = mk_her(200 + i, i[1]);
      tick();
      chk("stream_valid", HER_W'(m_her_valid), HER_W'(1));
      chk("stream_occ", HER_W'(occupancy), HER_W'(1));
      chk("stream_msgid", HER_W'(m_her_data[9:0]), HER_W'(10'(200 + i)));
    end
    s_her_valid = 1'b0;
    tick();
    chk("stream_empty", HER_W'(empty), HER_W'(1));

    // full queue: push with simultaneous pop is refused, accepted next cycle
    m_her_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      s_her_valid = 1'b1; s_her_data = mk_her(400 + i, 1'b0);
      tick();
    end
    s_her_data = mk_her(500, 1'b1); m_her_ready = 1'b1;
    chk("full_pop_s_ready", HER_W'(s_her_ready), '0);
    tick();
    chk("full_pop_occ", HER_W'(occupancy), HER_W'(15));
    chk("full_pop_s_ready2", HER_W'(s_her_ready), HER_W'(1));
    m_her_ready = 1'b0;
    tick();
    s_her_valid = 1'b0;
    chk("full_retry_occ", HER_W'(occupancy), HER_W'(16));
    m_her_ready = 1'b1;
    for (int i = 0; i < 16; i++) tick();
    chk("full_last_msgid", HER_W'(m_her_data[9:0]), HER_W'(10'(500)));
    tick();
    chk("full_drained", HER_W'(empty), HER_W'(1));

    // flush with 5 entries and a concurrent push
    m_her_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      s_her_valid = 1'b1; s_her_data = mk_her(600 + i, 1'b1);
      tick();
    end
    chk("flush_pre_occ", HER_W'(occupancy), HER_W'(5));
    flush = 1'b1; s_her_data = mk_her(700, 1'b1); m_her_ready = 1'b1;
    tick();
    flush = 1'b0; s_her_valid = 1'b0;
    chk("flush_occ", HER_W'(occupancy), '0);
    chk("flush_valid", HER_W'(m_her_valid), '0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("flush_no_emit", HER_W'(m_her_valid), '0);
    end

    // async reset while stalled
    do_reset();
    s_her_valid = 1'b1; s_her_data = mk_her(800, 1'b0);
    tick();
    s_her_valid = 1'b0;
    for (int i = 0; i < 3; i++) tick();
`ifdef PSPIN_HER_QUEUE_STATS_EN
    chk("stall_before_rst", HER_W'(stat_stall_cnt), HER_W'(3));
`endif
    #2 rstn = 1'b0;
    #1;
    chk("arst_valid", HER_W'(m_her_valid), '0);
    chk("arst_occ", HER_W'(occupancy), '0);
    chk("arst_data", m_her_data, '0);
    chk("arst_empty", HER_W'(empty), HER_W'(1));
    chk("arst_s_ready", HER_W'(s_her_ready), HER_W'(1));
`ifdef PSPIN_HER_QUEUE_STATS_EN
    chk("arst_stall", HER_W'(stat_stall_cnt), '0);
`endif
    @(negedge clk);
    rstn = 1'b1;
    tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
